// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Holds the register-address width, the MUX4 select encoding and the
// in-flight slot record used by the EX/MEM/WB/WB+1 tracking registers.
package hazard_fwd_unit_pkg;

    // Register address width (x0..x31).
    localparam int unsigned RA_W  = 5;
    // Width of the optional statistics counters.
    localparam int unsigned CNT_W = 32;
    // Width of one operand-mux select.
    localparam int unsigned SEL_W = 2;

    typedef logic [RA_W-1:0]  reg_addr_t;
    typedef logic [SEL_W-1:0] fwd_sel_t;

    // Operand MUX4 input numbering.
    localparam fwd_sel_t FWD_RF    = 2'b00;  // register file read
    localparam fwd_sel_t FWD_EXMEM = 2'b01;  // EX/MEM ALU result
    localparam fwd_sel_t FWD_MEMWB = 2'b10;  // MEM/WB writeback value
    localparam fwd_sel_t FWD_WB2   = 2'b11;  // value retired last cycle

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      we;
        logic      is_load;
    } slot_t;

    // A slot can supply register r only if it really writes a non-zero rd equal to r.
    function automatic logic slot_hit(input slot_t s, input reg_addr_t r);
        return s.valid && s.we && (s.rd == r) && (r != '0);
    endfunction

endpackage : hazard_fwd_unit_pkg

// File: rtl/hazard_fwd_unit_fwd_sel_gen.sv
// Priority select for one EX operand: the youngest producing slot wins.
module fwd_sel_gen
    import hazard_fwd_unit_pkg::*;
(
    input  logic     use_rs,
    input  logic     hit_ex,
    input  logic     hit_mem,
    input  logic     hit_wb,
    output fwd_sel_t sel_c
);

    // Youngest-first priority; an operand that is not read always takes the register file.
    always_comb begin
        sel_c = FWD_RF;
        if (use_rs) begin
            if (hit_ex) begin
                sel_c = FWD_EXMEM;
            end else if (hit_mem) begin
                sel_c = FWD_MEMWB;
            end else if (hit_wb) begin
                sel_c = FWD_WB2;
            end
        end
    end

endmodule : fwd_sel_gen

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage RISC-V pipeline.
// Tracks the destination of instructions in EX, MEM, WB and WB+1, produces the
// combinational load-use stall and registers the two EX operand-mux selects.
// Optional build macro HAZARD_STATS_EN adds saturating stall/forward counters.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            flush,
    output logic            stall,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
`endif
);

    slot_t    ex_q;
    slot_t    mem_q;
    slot_t    wb_q;
    slot_t    wb2_q;
    slot_t    ex_d;
    logic     advance_c;
    fwd_sel_t sel_a_c;
    fwd_sel_t sel_b_c;
    fwd_sel_t next_a_c;
    fwd_sel_t next_b_c;

    // The WB+1 slot mirrors the value the bypass input carries; no decision reads it.
    logic unused_wb2;
    assign unused_wb2 = ^wb2_q;

    // Load-use interlock: a load in EX cannot feed the very next instruction.
    always_comb begin
        stall = 1'b0;
        if (id_valid && !flush && ex_q.valid && ex_q.is_load && ex_q.we && (ex_q.rd != '0)) begin
            stall = (id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_q.rd));
        end
    end

    // Instruction entering EX; stalls and flushes turn it into a bubble.
    always_comb begin
        advance_c    = id_valid && !stall && !flush;
        ex_d         = '0;
        ex_d.valid   = advance_c;
        ex_d.rd      = id_rd;
        ex_d.we      = id_we;
        ex_d.is_load = id_is_load;
    end

    fwd_sel_gen u_sel_a (
        .use_rs  (id_use_rs1),
        .hit_ex  (slot_hit(ex_q,  id_rs1)),
        .hit_mem (slot_hit(mem_q, id_rs1)),
        .hit_wb  (slot_hit(wb_q,  id_rs1)),
        .sel_c   (sel_a_c)
    );

    fwd_sel_gen u_sel_b (
        .use_rs  (id_use_rs2),
        .hit_ex  (slot_hit(ex_q,  id_rs2)),
        .hit_mem (slot_hit(mem_q, id_rs2)),
        .hit_wb  (slot_hit(wb_q,  id_rs2)),
        .sel_c   (sel_b_c)
    );

    // Selects loaded into EX; bubbles always read the register file.
    always_comb begin
        next_a_c = FWD_RF;
        next_b_c = FWD_RF;
        if (advance_c) begin
            next_a_c = sel_a_c;
            next_b_c = sel_b_c;
        end
    end

    // Pipeline slot shift and registered operand selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            wb2_q     <= '0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            wb2_q     <= wb_q;
            wb_q      <= mem_q;
            mem_q     <= ex_q;
            ex_q      <= ex_d;
            fwd_a_sel <= next_a_c;
            fwd_b_sel <= next_b_c;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating event counters for stall cycles and forwarded instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (((next_a_c != FWD_RF) || (next_b_c != FWD_RF)) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule : hazard_fwd_unit
